// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_arb_pkg
// Purpose : Shared types and helpers for the Wishbone round-robin arbiters.
//           Holds the arbiter state encoding, the Wishbone CTI codes and the
//           round-robin next-index helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] c_CTI_INCR    = 3'b010;
  localparam logic [2:0] c_CTI_EOB     = 3'b111;

  // Index following idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end
    return idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin priority rotator. Returns the one-hot
//           requester found first when scanning upward from i_last+1 with
//           wrap-around. Returns zero when nothing is requested.
// Ports   : i_req   [N-1:0]  request vector
//           i_last  [IW-1:0] index of the previous winner
//           o_grant [N-1:0]  one-hot winner
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant
);

  int           w_sh;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_low;

  // Rotate the requests right so the scan start lands on bit 0, isolate the
  // lowest set bit, then rotate back left by the same amount (expressed as a
  // right rotation by N-w_sh, which is a no-op when w_sh is zero).
  always_comb begin
    w_sh    = rr_next(int'(i_last), N);
    w_rot   = N'({i_req, i_req} >> w_sh);
    w_low   = w_rot & (~w_rot + N'(1));
    o_grant = N'({w_low, w_low} >> (N - w_sh));
  end

endmodule
`default_nettype wire

// File: rtl/wb_hram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_hram_arbiter
// Purpose : Round-robin Wishbone B4 arbiter sharing the HyperRAM data port
//           between several masters. Grant is held for a master's whole cyc
//           so bursts are never split; a per-transfer watchdog aborts a
//           stalled transfer.
// Ports   : wb_clk_i / wb_rst_i      clock, synchronous active-high reset
//           m_*_i                    packed master request buses
//           m_dat_o/m_ack_o/m_err_o  responses (data broadcast)
//           s_*_o / s_*_i            slave side towards wb_hyper
//           grant_o                  registered one-hot grant, 0 when idle
//           timeout_o                one-cycle pulse on watchdog abort
// Revision: 1.0 - initial release
// ============================================================================
module wb_hram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]  m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]  m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]     m_we_i,
  input  logic [NUM_MASTERS-1:0]     m_cyc_i,
  input  logic [NUM_MASTERS-1:0]     m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]   m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]   m_bte_i,
  output logic [DW-1:0]              m_dat_o,
  output logic [NUM_MASTERS-1:0]     m_ack_o,
  output logic [NUM_MASTERS-1:0]     m_err_o,
  output logic [AW-1:0]              s_adr_o,
  output logic [DW-1:0]              s_dat_o,
  output logic [DW/8-1:0]            s_sel_o,
  output logic                       s_we_o,
  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic [2:0]                 s_cti_o,
  output logic [1:0]                 s_bte_o,
  input  logic [DW-1:0]              s_dat_i,
  input  logic                       s_ack_i,
  input  logic                       s_err_i,
  output logic [NUM_MASTERS-1:0]     grant_o,
  output logic                       timeout_o
);

  localparam int              IW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int              SW         = DW / 8;
  localparam logic [IW-1:0]   c_LAST_RST = IW'(NUM_MASTERS - 1);
  localparam logic [15:0]     c_TIMEOUT  = 16'(TIMEOUT);

  arb_state_t              r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0]  r_grant, w_grant_nxt;
  logic [IW-1:0]           r_gidx,  w_gidx_nxt;
  logic [IW-1:0]           r_last,  w_last_nxt;
  logic [15:0]             r_wdog,  w_wdog_nxt;
  logic [NUM_MASTERS-1:0]  w_win;
  logic [IW-1:0]           w_win_idx;
  logic                    w_in_grant;
  logic                    w_gcyc;
  logic                    w_wait;
  logic                    w_timeout;

  logic [AW-1:0] w_adr [NUM_MASTERS];
  logic [DW-1:0] w_dat [NUM_MASTERS];
  logic [SW-1:0] w_sel [NUM_MASTERS];
  logic [2:0]    w_cti [NUM_MASTERS];
  logic [1:0]    w_bte [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign w_adr[gi] = m_adr_i[gi*AW +: AW];
      assign w_dat[gi] = m_dat_i[gi*DW +: DW];
      assign w_sel[gi] = m_sel_i[gi*SW +: SW];
      assign w_cti[gi] = m_cti_i[gi*3 +: 3];
      assign w_bte[gi] = m_bte_i[gi*2 +: 2];
    end
  endgenerate

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .i_req   (m_cyc_i),
    .i_last  (r_last),
    .o_grant (w_win)
  );

  always_comb begin
    w_win_idx = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (w_win[j]) begin
        w_win_idx = IW'(j);
      end
    end
  end

  // Slave side: address/data path always follows the registered owner; only
  // cyc/stb are gated so the slave sees an idle bus outside GRANT.
  assign w_in_grant = (r_state == ST_GRANT);
  assign w_gcyc     = m_cyc_i[r_gidx];
  assign s_adr_o    = w_adr[r_gidx];
  assign s_dat_o    = w_dat[r_gidx];
  assign s_sel_o    = w_sel[r_gidx];
  assign s_we_o     = m_we_i[r_gidx];
  assign s_cti_o    = w_cti[r_gidx];
  assign s_bte_o    = w_bte[r_gidx];
  assign s_cyc_o    = w_in_grant & w_gcyc;
  assign s_stb_o    = w_in_grant & w_gcyc & m_stb_i[r_gidx];
  assign m_dat_o    = s_dat_i;
  assign grant_o    = r_grant;
  assign timeout_o  = w_timeout;

  // A waiting cycle: strobe presented and the slave has not answered yet.
  assign w_wait = s_stb_o & ~s_ack_i & ~s_err_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= c_LAST_RST;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
      r_wdog  <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    w_wdog_nxt  = '0;
    w_timeout   = 1'b0;
    m_ack_o     = '0;
    m_err_o     = '0;

    case (r_state)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          w_grant_nxt = w_win;
          w_gidx_nxt  = w_win_idx;
          w_state_nxt = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!w_gcyc) begin
          // Release always passes through IDLE so the slave sees cyc fall.
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_gidx;
          w_grant_nxt = '0;
        end else begin
          m_ack_o[r_gidx] = s_ack_i;
          m_err_o[r_gidx] = s_err_i;
          if (w_wait) begin
            if (r_wdog == c_TIMEOUT) begin
              w_timeout       = 1'b1;
              m_err_o[r_gidx] = 1'b1;
              w_state_nxt     = ST_ABORT;
            end else begin
              w_wdog_nxt = r_wdog + 16'd1;
            end
          end
        end
      end

      ST_ABORT: begin
        // Bus is already dropped; late slave responses are swallowed here.
        if (!w_gcyc) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_gidx;
          w_grant_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_hram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_hram_arbiter
// Purpose : Directed self-checking bench for wb_hram_arbiter (3 masters,
//           watchdog TIMEOUT=16).
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_hram_arbiter;
  import wb_arb_pkg::*;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*AW-1:0]  m_adr_i;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*DW/8-1:0] m_sel_i;
  logic [NM-1:0]     m_we_i;
  logic [NM-1:0]     m_cyc_i;
  logic [NM-1:0]     m_stb_i;
  logic [NM*3-1:0]   m_cti_i;
  logic [NM*2-1:0]   m_bte_i;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o;
  logic [NM-1:0]     m_err_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o;
  logic              s_cyc_o;
  logic              s_stb_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i;
  logic              s_err_i;
  logic [NM-1:0]     grant_o;
  logic              timeout_o;

  logic auto_ack = 1'b1;
  logic man_ack  = 1'b0;
  logic slave_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycnt  = 0;
  int viol   = 0;
  int ack_cnt [NM] = '{default: 0};
  int rel_cyc [NM] = '{default: 0};
  logic [NM-1:0] g_prev = '0;
  logic [NM-1:0] glog [$];
  int            gcyc [$];

  wb_hram_arbiter #(
    .NUM_MASTERS (NM),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT     (TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_we_i    (m_we_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_cti_i   (m_cti_i),
    .m_bte_i   (m_bte_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_we_o    (s_we_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_cti_o   (s_cti_o),
    .s_bte_o   (s_bte_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .grant_o   (grant_o),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycnt <= cycnt + 1;

  // Slave acks every other cycle while strobed.
  always @(negedge clk) slave_ack = s_cyc_o & s_stb_o & ~slave_ack;
  assign s_ack_i = auto_ack ? slave_ack : man_ack;

  // Records grant tenures, per-master acks and invariant breaches.
  always @(negedge clk) begin
    #3;
    if (grant_o !== g_prev && grant_o !== '0) begin
      glog.push_back(grant_o);
      gcyc.push_back(cycnt);
    end
    g_prev = grant_o;
    for (int m = 0; m < NM; m++) begin
      if (m_ack_o[m]) ack_cnt[m]++;
    end
    if ($countones(grant_o) > 1 || $countones(m_ack_o | m_err_o) > 1 ||
        ((m_ack_o | m_err_o) & ~(m_cyc_i & grant_o)) != '0)
      viol++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0;
    m_sel_i = '1; m_cti_i = '0; m_bte_i = '0;
    s_err_i = 1'b0; s_dat_i = 32'hDEAD_BEEF;
    auto_ack = 1'b1; man_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // One master doing `tenures` transfers of `beats` each, dropping cyc for
  // one cycle between tenures.
  task automatic run_master(input int m, input int tenures, input int beats, input int dly);
    int b;
    int guard;
    repeat (dly) tick();
    for (int t = 0; t < tenures; t++) begin
      b = 0;
      guard = 0;
      m_cyc_i[m] = 1'b1;
      m_stb_i[m] = 1'b1;
      while (b < beats && guard < 300) begin
        m_adr_i[m*AW +: AW] = 32'(32'h1000 * (m + 1) + 4 * b);
        m_cti_i[m*3 +: 3] = (beats == 1) ? c_CTI_CLASSIC :
                            ((b == beats - 1) ? c_CTI_EOB : c_CTI_INCR);
        @(negedge clk);
        #2;
        if (m_ack_o[m]) b++;
        tick();
        guard++;
      end
      checks++;
      if (b != beats) begin
        errors++;
        $display("FAIL master%0d_beats: got %0d expected %0d", m, b, beats);
      end
      m_cyc_i[m] = 1'b0;
      m_stb_i[m] = 1'b0;
      if (t == 0) rel_cyc[m] = cycnt;
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL reset_grant: got %b expected 000", grant_o); end
    checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin errors++; $display("FAIL reset_bus: got cyc=%b stb=%b expected 0 0", s_cyc_o, s_stb_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
    checks++; if ((m_ack_o | m_err_o) !== 3'b000) begin errors++; $display("FAIL reset_resp: got %b expected 000", m_ack_o | m_err_o); end
  endtask

  task automatic test_single();
    do_reset();
    m_adr_i[AW +: AW] = 32'h0000_0040;
    m_adr_i[0 +: AW]  = 32'h1234_5678;
    m_cti_i[3 +: 3]   = c_CTI_CLASSIC;
    m_cyc_i[1] = 1'b1;
    m_stb_i[1] = 1'b1;
    #1;
    checks++; if (s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_cyc0: got %b expected 0", s_cyc_o); end
    tick();
    #1;
    checks++; if (grant_o !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", grant_o); end
    checks++; if (s_cyc_o !== 1'b1) begin errors++; $display("FAIL single_cyc1: got %b expected 1", s_cyc_o); end
    checks++; if (s_adr_o !== 32'h0000_0040) begin errors++; $display("FAIL single_adr: got %h expected 00000040", s_adr_o); end
    m_adr_i[0 +: AW] = 32'hAAAA_0000;
    #1;
    checks++; if (s_adr_o !== 32'h0000_0040) begin errors++; $display("FAIL single_iso: got %h expected 00000040", s_adr_o); end
    @(negedge clk);
    #2;
    checks++; if (m_ack_o !== 3'b010) begin errors++; $display("FAIL single_ack: got %b expected 010", m_ack_o); end
    checks++; if (m_dat_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_dat: got %h expected deadbeef", m_dat_o); end
    tick();
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    #1;
    checks++; if (s_cyc_o !== 1'b0 || grant_o !== 3'b010) begin errors++; $display("FAIL single_drop: got cyc=%b grant=%b expected 0 010", s_cyc_o, grant_o); end
    tick();
    #1;
    checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL single_release: got %b expected 000", grant_o); end
  endtask

  task automatic test_contention();
    int base;
    logic [NM-1:0] exp_g [3];
    exp_g = '{3'b001, 3'b100, 3'b001};
    do_reset();
    base = glog.size();
    fork
      run_master(0, 2, 1, 0);
      run_master(2, 1, 1, 0);
    join
    checks++;
    if (glog.size() - base != 3) begin
      errors++; $display("FAIL contention_count: got %0d expected 3", glog.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (glog[base+i] !== exp_g[i]) begin errors++; $display("FAIL contention_order[%0d]: got %b expected %b", i, glog[base+i], exp_g[i]); end
      end
      checks++; if (gcyc[base+1] != rel_cyc[0] + 2) begin errors++; $display("FAIL contention_latency: got cycle %0d expected %0d", gcyc[base+1], rel_cyc[0] + 2); end
    end
  endtask

  task automatic test_round_robin();
    int base;
    logic [NM-1:0] exp_g [6];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    base = glog.size();
    fork
      run_master(0, 2, 1, 0);
      run_master(1, 2, 1, 0);
      run_master(2, 2, 1, 0);
    join
    checks++;
    if (glog.size() - base != 6) begin
      errors++; $display("FAIL rr_count: got %0d expected 6", glog.size() - base);
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (glog[base+i] !== exp_g[i]) begin errors++; $display("FAIL rr_order[%0d]: got %b expected %b", i, glog[base+i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_burst();
    int base;
    int a0;
    int a2;
    do_reset();
    base = glog.size();
    a0 = ack_cnt[0];
    a2 = ack_cnt[2];
    fork
      run_master(2, 1, 8, 0);
      run_master(0, 1, 1, 3);
    join
    checks++; if (ack_cnt[2] - a2 != 8) begin errors++; $display("FAIL burst_acks2: got %0d expected 8", ack_cnt[2] - a2); end
    checks++; if (ack_cnt[0] - a0 != 1) begin errors++; $display("FAIL burst_acks0: got %0d expected 1", ack_cnt[0] - a0); end
    checks++;
    if (glog.size() - base != 2) begin
      errors++; $display("FAIL burst_tenures: got %0d expected 2", glog.size() - base);
    end else begin
      checks++; if (glog[base] !== 3'b100 || glog[base+1] !== 3'b001) begin errors++; $display("FAIL burst_order: got %b,%b expected 100,001", glog[base], glog[base+1]); end
      checks++; if (gcyc[base+1] != rel_cyc[2] + 2) begin errors++; $display("FAIL burst_handover: got cycle %0d expected %0d", gcyc[base+1], rel_cyc[2] + 2); end
    end
  endtask

  task automatic test_timeout();
    int found;
    logic [NM-1:0] err_at;
    do_reset();
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    found    = -1;
    err_at   = '0;
    m_adr_i[AW +: AW] = 32'h0000_0080;
    m_cyc_i[1] = 1'b1;
    m_stb_i[1] = 1'b1;
    tick();
    #1;
    checks++; if (s_stb_o !== 1'b1) begin errors++; $display("FAIL to_stb: got %b expected 1", s_stb_o); end
    for (int i = 1; i <= 40 && found < 0; i++) begin
      tick();
      #1;
      if (timeout_o === 1'b1) begin
        found  = i;
        err_at = m_err_o;
      end
    end
    checks++; if (found != 16) begin errors++; $display("FAIL to_delay: got %0d expected 16", found); end
    checks++; if (err_at !== 3'b010) begin errors++; $display("FAIL to_err: got %b expected 010", err_at); end
    tick();
    #1;
    checks++; if (s_cyc_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL to_abort: got cyc=%b to=%b expected 0 0", s_cyc_o, timeout_o); end
    checks++; if (grant_o !== 3'b010) begin errors++; $display("FAIL to_hold: got %b expected 010", grant_o); end
    man_ack = 1'b1;
    #1;
    checks++; if ((m_ack_o | m_err_o) !== 3'b000) begin errors++; $display("FAIL to_late_ack: got %b expected 000", m_ack_o | m_err_o); end
    tick();
    man_ack = 1'b0;
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    tick();
    #1;
    checks++; if (grant_o !== 3'b000) begin errors++; $display("FAIL to_release: got %b expected 000", grant_o); end
    auto_ack = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_cti_i[6 +: 3] = c_CTI_INCR;
    m_cyc_i[2] = 1'b1;
    m_stb_i[2] = 1'b1;
    repeat (4) tick();
    #1;
    checks++; if (s_cyc_o !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b expected 1", s_cyc_o); end
    rst = 1'b1;
    tick();
    #1;
    checks++; if (s_cyc_o !== 1'b0 || grant_o !== 3'b000) begin errors++; $display("FAIL rmid_drop: got cyc=%b grant=%b expected 0 000", s_cyc_o, grant_o); end
    rst = 1'b0;
    m_cyc_i = 3'b011;
    m_stb_i = 3'b011;
    tick();
    #1;
    checks++; if (grant_o !== 3'b001) begin errors++; $display("FAIL rmid_first: got %b expected 001", grant_o); end
    m_cyc_i = '0;
    m_stb_i = '0;
    repeat (2) tick();
  endtask

  task automatic test_invariants();
    checks++; if (viol != 0) begin errors++; $display("FAIL invariants: got %0d breaches expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
